delay_scheduler: RTL and testbench
==================================

# delay_scheduler

Time-multiplexes one shared `Delay` datapath across `NUM_CH` sound sources at the audio sample rate. An internal fractional-rate generator derives a 44.1 kHz sample tick from the 50 MHz system clock. On each tick the block snapshots every channel's theta, distance and sample, then issues them one at a time to the delay unit over a req/ack handshake. When all results have returned, it publishes them together as one output frame.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `SAMPLE_HZ`, 44_100: audio sample rate. Must be less than `CLK_HZ`.
- `NUM_CH`, 4: number of source channels, 1–16.
- `CH_W`, $clog2(NUM_CH) (minimum 1): width of the channel index.

Ports:
- `clk`  in  1  system clock. All logic is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ch_theta`  in  8*NUM_CH  per-channel angle; channel i occupies bits [8i+7:8i].
- `ch_distance`  in  8*NUM_CH  per-channel distance, packed the same way as `ch_theta`.
- `ch_sample`  in  16*NUM_CH  per-channel input sample; channel i occupies bits [16i+15:16i].
- `dly_req`  out  1  a request to the delay unit is valid.
- `dly_ch`  out  CH_W  index of the channel being issued.
- `dly_theta`  out  8  theta for the issued channel.
- `dly_distance`  out  8  distance for the issued channel.
- `dly_signal_in`  out  16  sample for the issued channel.
- `dly_ack`  in  1  the delay unit accepts the request; `dly_signal_out` is valid in the same cycle.
- `dly_signal_out`  in  16  delayed sample returned by the delay unit.
- `out_samples`  out  16*NUM_CH  last completed frame, packed like `ch_sample`.
- `frame_valid`  out  1  one-cycle pulse marking a new frame.
- `sample_tick`  out  1  one-cycle pulse at the sample rate.
- `busy`  out  1  high whenever the state is not IDLE.
- `overrun`  out  1  sticky flag: a tick was dropped because a frame was still in progress.
- `overrun_clr`  in  1  clears `overrun`.

## Operation

- **Tick generator.** The accumulator `acc` has width $clog2(CLK_HZ)+1. Each cycle it computes `nxt = acc + SAMPLE_HZ`.
  - If `nxt >= CLK_HZ`: `acc <= nxt - CLK_HZ` and `sample_tick = 1`.
  - Otherwise: `acc <= nxt` and `sample_tick = 0`.
  - The long-run rate is exact. With the default parameters, ticks are spaced 1133 or 1134 cycles apart.
- **IDLE.** When a tick arrives, latch all of `ch_*` into snapshot registers, set ch=0 and go to ISSUE.
- **ISSUE.** Load `dly_ch`, `dly_theta`, `dly_distance` and `dly_signal_in` from the snapshot for channel ch. `dly_req` stays 0. Go to WAIT.
- **WAIT.** Hold `dly_req` = 1 with a stable payload until `dly_ack` is seen.
  - On ack, store `dly_signal_out` into result slot ch.
  - If ch == NUM_CH-1, go to DONE. Otherwise increment ch and go to ISSUE.
- **DONE.** Copy the result slots to `out_samples`, pulse `frame_valid` for one cycle, and return to IDLE.
- **Ignored inputs.** `dly_ack` is ignored whenever `dly_req` = 0. `ch_*` inputs are only sampled on the tick.
- **Overrun.** A tick that arrives in any state other than IDLE sets `overrun`. That tick is dropped, and the frame already in progress completes normally.
  - `overrun_clr` clears `overrun`.
  - If a set and a clear occur in the same cycle, the set wins.

## Timing

- **Reset values.** During reset every output is 0: `dly_req`, payload, `out_samples`, `frame_valid`, `sample_tick`, `busy`, `overrun`. The state returns to IDLE and `acc` returns to 0.
- **First tick.** With the default parameters, `sample_tick` first goes high in the 1134th cycle after `rst` falls.
- **Cycle-by-cycle sequence**, for a tick in cycle T and zero-wait acks:
  - ISSUE ch0 in T+1.
  - `dly_req` high in T+2.
  - Channel k is requested in cycle T+2+2k.
  - `frame_valid` rises in T+2·NUM_CH+1, which is T+9 for the default NUM_CH=4.
  - `out_samples` changes in the same cycle as `frame_valid` and holds until the next frame.
- **Gaps.** Each cycle of ack delay extends the frame by one cycle. `dly_req` drops for exactly one cycle between consecutive channels.
- **Reset mid-frame.** `dly_req` and `busy` drop immediately. The partial frame is discarded; no `frame_valid` is produced and `out_samples` is cleared to 0.
- **Tick in DONE.** A tick in the same cycle as DONE counts as an overrun.

## Structure

- **Shared package `sched_pkg`:**
  - default `CLK_HZ` and `SAMPLE_HZ` constants, aligned with the existing `ClkPeri` and `SoundPeri` defines;
  - the state enumeration `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- **Sub-module `sample_tick_gen`:** the accumulator and `sample_tick` logic. It is reused elsewhere in the design as the system sample strobe.
- **Top level:** the FSM, the snapshot registers, the result slots and the overrun flag.

## Test plan

- **Reset and tick rate.** Release `rst` and count ticks over 500,000 cycles. Expect exactly 441 ticks, the first in cycle 1134, and every spacing either 1133 or 1134.
- **Zero-wait frame.** Stub `dly_ack` = `dly_req` and set `dly_signal_out` = `dly_signal_in` ^ 16'hFFFF. Drive `ch_sample` = {16'h4444, 16'h3333, 16'h2222, 16'h1111}. Expect `frame_valid` at tick+9 with `out_samples` = {BBBB, CCCC, DDDD, EEEE}, and `dly_ch` sequencing 0, 1, 2, 3.
- **Ack stall.** Delay the ack for channel 2 by 5 cycles. Expect `frame_valid` at tick+14, with the payload held stable throughout the stall.
- **Overrun.** Withhold `dly_ack` across the next tick. Expect `overrun` = 1, one frame rather than two, and `frame_valid` after the ack is finally released. Then assert `overrun_clr` and `sample_tick` in the same cycle: `overrun` stays 1.
- **Reset mid-frame.** Assert `rst` while in WAIT on ch1. Expect `dly_req`, `busy` and `out_samples` to go to 0 at once, and no `frame_valid`. After release, the next tick produces a complete frame.
- **Snapshot isolation.** Change `ch_theta` while a frame is in progress. Expect `dly_theta` for the remaining channels to carry the values captured at the tick.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared constants and state type for the delay scheduler
// and the system sample strobe.
package sched_pkg;

   // Default system clock and audio rate (ClkPeri / SoundPeri).
   localparam int DEF_CLK_HZ    = 50_000_000;
   localparam int DEF_SAMPLE_HZ = 44_100;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Fractional-rate strobe: one pulse per SAMPLE_HZ period of CLK_HZ,
// exact over the long run.
module sample_tick_gen
   import sched_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int SAMPLE_HZ = DEF_SAMPLE_HZ
) (
   input  logic clk,
   input  logic rst,
   output logic sample_tick
);

   localparam int AW = $clog2(CLK_HZ) + 1;
   localparam logic [AW-1:0] STEP = AW'(SAMPLE_HZ);
   localparam logic [AW-1:0] WRAP = AW'(CLK_HZ);

   logic [AW-1:0] acc;
   logic [AW-1:0] nxt;

   assign nxt         = acc + STEP;
   assign sample_tick = (nxt >= WRAP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (sample_tick)
         acc <= nxt - WRAP;
      else
         acc <= nxt;
   end

endmodule

// File: rtl/delay_scheduler.sv
// Time-multiplexes one Delay datapath across NUM_CH sources,
// one frame per audio sample tick.
module delay_scheduler
   import sched_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int SAMPLE_HZ = DEF_SAMPLE_HZ,
   parameter int NUM_CH    = 4,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_CH-1:0]  ch_theta,
   input  logic [8*NUM_CH-1:0]  ch_distance,
   input  logic [16*NUM_CH-1:0] ch_sample,
   output logic                 dly_req,
   output logic [CH_W-1:0]      dly_ch,
   output logic [7:0]           dly_theta,
   output logic [7:0]           dly_distance,
   output logic [15:0]          dly_signal_in,
   input  logic                 dly_ack,
   input  logic [15:0]          dly_signal_out,
   output logic [16*NUM_CH-1:0] out_samples,
   output logic                 frame_valid,
   output logic                 sample_tick,
   output logic                 busy,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int LAST_I = NUM_CH - 1;
   localparam logic [CH_W-1:0] LAST = CH_W'(LAST_I);

   state_t               state;
   logic [CH_W-1:0]      ch;
   logic [8*NUM_CH-1:0]  snap_theta;
   logic [8*NUM_CH-1:0]  snap_distance;
   logic [16*NUM_CH-1:0] snap_sample;
   logic [16*NUM_CH-1:0] res;
   logic [16*NUM_CH-1:0] frame;
   logic                 tick;

   sample_tick_gen #(
      .CLK_HZ    (CLK_HZ),
      .SAMPLE_HZ (SAMPLE_HZ)
   ) u_tick (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (tick)
   );

   assign sample_tick = tick;
   assign busy        = (state != IDLE);

   // Last result bypasses its slot so the frame lands as DONE begins.
   always_comb begin
      frame = res;
      frame[16*LAST_I +: 16] = dly_signal_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         ch            <= '0;
         snap_theta    <= '0;
         snap_distance <= '0;
         snap_sample   <= '0;
         res           <= '0;
         dly_req       <= 1'b0;
         dly_ch        <= '0;
         dly_theta     <= '0;
         dly_distance  <= '0;
         dly_signal_in <= '0;
         out_samples   <= '0;
         frame_valid   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (tick) begin
                  snap_theta    <= ch_theta;
                  snap_distance <= ch_distance;
                  snap_sample   <= ch_sample;
                  ch            <= '0;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               dly_ch        <= ch;
               dly_theta     <= snap_theta[8*ch +: 8];
               dly_distance  <= snap_distance[8*ch +: 8];
               dly_signal_in <= snap_sample[16*ch +: 16];
               dly_req       <= 1'b1;
               state         <= WAIT;
            end
            WAIT: begin
               if (dly_ack) begin
                  res[16*ch +: 16] <= dly_signal_out;
                  dly_req          <= 1'b0;
                  if (ch == LAST) begin
                     out_samples <= frame;
                     frame_valid <= 1'b1;
                     state       <= DONE;
                  end else begin
                     ch    <= ch + 1'b1;
                     state <= ISSUE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A tick outside IDLE is dropped; flagging it beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overrun <= 1'b0;
      else if (tick && state != IDLE)
         overrun <= 1'b1;
      else if (overrun_clr)
         overrun <= 1'b0;
   end

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: tick-rate model, frame timing,
// stalls, overrun, reset mid-frame and snapshot isolation.
module tb_delay_scheduler;

   localparam int N        = 4;
   localparam int CW       = 2;
   localparam int RATE_CYC = 40_000;
   localparam longint S_HZ = 44_100;
   localparam longint C_HZ = 50_000_000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [8*N-1:0]  ch_theta = '0;
   logic [8*N-1:0]  ch_distance = '0;
   logic [16*N-1:0] ch_sample = '0;
   logic            dly_req;
   logic [CW-1:0]   dly_ch;
   logic [7:0]      dly_theta;
   logic [7:0]      dly_distance;
   logic [15:0]     dly_signal_in;
   logic            dly_ack;
   logic [15:0]     dly_signal_out;
   logic [16*N-1:0] out_samples;
   logic            frame_valid;
   logic            sample_tick;
   logic            busy;
   logic            overrun;
   logic            overrun_clr = 1'b0;
   logic            ack_ok = 1'b1;

   int n_pass = 0;
   int n_total = 0;

   int              hs_n, fv_cnt, fv_cyc, stall_bad, tick_seen;
   int              hs_cyc [N];
   int              ch_obs [N];
   logic [7:0]      th_obs [N];
   logic [7:0]      di_obs [N];
   logic [15:0]     si_obs [N];
   logic [16*N-1:0] fv_data;

   // Delay-unit stub: inverts the sample, ack driven by the bench.
   assign dly_ack        = ack_ok;
   assign dly_signal_out = dly_signal_in ^ 16'hFFFF;

   always #5 clk = ~clk;

   delay_scheduler #(
      .CLK_HZ    (50_000_000),
      .SAMPLE_HZ (44_100),
      .NUM_CH    (N),
      .CH_W      (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ch_theta       (ch_theta),
      .ch_distance    (ch_distance),
      .ch_sample      (ch_sample),
      .dly_req        (dly_req),
      .dly_ch         (dly_ch),
      .dly_theta      (dly_theta),
      .dly_distance   (dly_distance),
      .dly_signal_in  (dly_signal_in),
      .dly_ack        (dly_ack),
      .dly_signal_out (dly_signal_out),
      .out_samples    (out_samples),
      .frame_valid    (frame_valid),
      .sample_tick    (sample_tick),
      .busy           (busy),
      .overrun        (overrun),
      .overrun_clr    (overrun_clr)
   );

   task automatic wait_tick(output bit ok, output int w, output int fvs);
      ok = 0;
      w = 0;
      fvs = 0;
      while (!ok && w < 2500) begin
         @(negedge clk);
         w++;
         if (frame_valid === 1'b1) fvs++;
         if (sample_tick === 1'b1) ok = 1;
      end
   endtask

   // Runs from the tick cycle (c=0), acting as the delay unit
   // and recording handshakes and frames relative to the tick.
   task automatic collect(input int stall_ch, input int stall_n,
                          input int chg_at, input bit clr_on_tick,
                          input int max_cyc);
      int waited = 0;
      logic [39:0] held = '0;
      bit hs;
      hs_n = 0;
      fv_cnt = 0;
      fv_cyc = -1;
      stall_bad = 0;
      tick_seen = 0;
      for (int k = 0; k < N; k++) hs_cyc[k] = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         overrun_clr = clr_on_tick && (sample_tick === 1'b1);
         if (sample_tick === 1'b1) tick_seen++;
         if (c == chg_at) begin
            ch_theta = ~ch_theta;
            ch_distance = ~ch_distance;
         end
         hs = 0;
         ack_ok = 1'b1;
         if (dly_req === 1'b1) begin
            if (int'(dly_ch) == stall_ch && waited < stall_n) begin
               if (waited == 0)
                  held = {dly_theta, dly_distance, dly_signal_in};
               else if (held !== {dly_theta, dly_distance, dly_signal_in})
                  stall_bad++;
               waited++;
               ack_ok = 1'b0;
            end else begin
               hs = 1;
               if (int'(dly_ch) == stall_ch && waited > 0 &&
                   held !== {dly_theta, dly_distance, dly_signal_in})
                  stall_bad++;
            end
         end
         if (hs) begin
            if (hs_n < N) begin
               hs_cyc[hs_n] = c;
               ch_obs[hs_n] = int'(dly_ch);
               th_obs[hs_n] = dly_theta;
               di_obs[hs_n] = dly_distance;
               si_obs[hs_n] = dly_signal_in;
            end
            hs_n++;
         end
         if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_cyc = c;
            fv_data = out_samples;
         end
      end
      overrun_clr = 1'b0;
      ack_ok = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({dly_req, frame_valid, sample_tick, busy, overrun} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {dly_req, frame_valid, sample_tick, busy, overrun});
      else n_pass++;
      n_total++;
      if ({dly_ch, dly_theta, dly_distance, dly_signal_in} !== '0)
         $display("FAIL reset_payload: got %h want 0",
                  {dly_ch, dly_theta, dly_distance, dly_signal_in});
      else n_pass++;
      n_total++;
      if (out_samples !== '0)
         $display("FAIL reset_out: got %h want 0", out_samples);
      else n_pass++;
   endtask

   task automatic test_tick_rate();
      int cnt = 0, first = -1, last = -1, bad_gap = 0, mism = 0;
      int exp_cnt;
      bit exp_t;
      rst = 1'b0;
      for (int k = 1; k <= RATE_CYC; k++) begin
         exp_t = ((longint'(k) * S_HZ) / C_HZ) != ((longint'(k - 1) * S_HZ) / C_HZ);
         if (sample_tick !== exp_t) mism++;
         if (sample_tick === 1'b1) begin
            if (first < 0) first = k;
            else if (k - last != 1133 && k - last != 1134) bad_gap++;
            last = k;
            cnt++;
         end
         @(negedge clk);
      end
      exp_cnt = int'((longint'(RATE_CYC) * S_HZ) / C_HZ);
      n_total++;
      if (first != 1134) $display("FAIL first_tick: got %0d want 1134", first);
      else n_pass++;
      n_total++;
      if (cnt != exp_cnt) $display("FAIL tick_count: got %0d want %0d", cnt, exp_cnt);
      else n_pass++;
      n_total++;
      if (bad_gap != 0) $display("FAIL tick_gap: got %0d bad gaps want 0", bad_gap);
      else n_pass++;
      n_total++;
      if (mism != 0) $display("FAIL tick_model: got %0d mismatching cycles want 0", mism);
      else n_pass++;
   endtask

   task automatic test_zero_wait();
      logic [16*N-1:0] smp = 64'h4444_3333_2222_1111;
      logic [8*N-1:0] th = $urandom;
      logic [8*N-1:0] di = $urandom;
      bit ok;
      int w, fvs, bad = 0;
      ch_sample = smp;
      ch_theta = th;
      ch_distance = di;
      wait_tick(ok, w, fvs);
      n_total++;
      if (!ok) $display("FAIL zw_tick: got no tick want tick within 2500");
      else n_pass++;
      collect(-1, 0, 0, 1'b0, 20);
      n_total++;
      if (fv_cnt != 1 || fv_cyc != 9)
         $display("FAIL zw_frame_time: got %0d frames at +%0d want 1 at +9", fv_cnt, fv_cyc);
      else n_pass++;
      n_total++;
      if (fv_data !== 64'hBBBB_CCCC_DDDD_EEEE)
         $display("FAIL zw_frame_data: got %h want bbbbccccddddeeee", fv_data);
      else n_pass++;
      n_total++;
      if (hs_n != N) $display("FAIL zw_handshakes: got %0d want %0d", hs_n, N);
      else n_pass++;
      for (int k = 0; k < N; k++)
         if (hs_cyc[k] != 2 + 2 * k || ch_obs[k] != k || th_obs[k] !== th[8*k +: 8] ||
             di_obs[k] !== di[8*k +: 8] || si_obs[k] !== smp[16*k +: 16])
            bad++;
      n_total++;
      if (bad != 0) $display("FAIL zw_sequence: got %0d bad requests want 0", bad);
      else n_pass++;
      n_total++;
      if (out_samples !== 64'hBBBB_CCCC_DDDD_EEEE)
         $display("FAIL zw_hold: got %h want bbbbccccddddeeee", out_samples);
      else n_pass++;
   endtask

   task automatic test_ack_stall();
      logic [16*N-1:0] smp = {$urandom, $urandom};
      bit ok;
      int w, fvs;
      ch_sample = smp;
      ch_theta = $urandom;
      ch_distance = $urandom;
      wait_tick(ok, w, fvs);
      n_total++;
      if (!ok) $display("FAIL st_tick: got no tick want tick within 2500");
      else n_pass++;
      collect(2, 5, 0, 1'b0, 30);
      n_total++;
      if (fv_cnt != 1 || fv_cyc != 14)
         $display("FAIL st_frame_time: got %0d frames at +%0d want 1 at +14", fv_cnt, fv_cyc);
      else n_pass++;
      n_total++;
      if (stall_bad != 0) $display("FAIL st_stable: got %0d payload changes want 0", stall_bad);
      else n_pass++;
      n_total++;
      if (hs_cyc[2] != 11) $display("FAIL st_ack_cycle: got +%0d want +11", hs_cyc[2]);
      else n_pass++;
      n_total++;
      if (fv_data !== (smp ^ {N{16'hFFFF}}))
         $display("FAIL st_frame_data: got %h want %h", fv_data, smp ^ {N{16'hFFFF}});
      else n_pass++;
   endtask

   task automatic test_overrun();
      logic [16*N-1:0] smp = {$urandom, $urandom};
      bit ok;
      int w, fvs;
      ch_sample = smp;
      wait_tick(ok, w, fvs);
      collect(1, 1200, 0, 1'b0, 1300);
      n_total++;
      if (overrun !== 1'b1) $display("FAIL ov_set: got %b want 1", overrun);
      else n_pass++;
      n_total++;
      if (tick_seen != 1 || fv_cnt != 1 || hs_n != N)
         $display("FAIL ov_one_frame: got ticks=%0d frames=%0d hs=%0d want 1 1 %0d",
                  tick_seen, fv_cnt, hs_n, N);
      else n_pass++;
      n_total++;
      if (fv_cyc != 1209) $display("FAIL ov_frame_time: got +%0d want +1209", fv_cyc);
      else n_pass++;
      n_total++;
      if (fv_data !== (smp ^ {N{16'hFFFF}}) || busy !== 1'b0)
         $display("FAIL ov_frame: got %h busy=%b want %h busy=0",
                  fv_data, busy, smp ^ {N{16'hFFFF}});
      else n_pass++;
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      n_total++;
      if (overrun !== 1'b0) $display("FAIL ov_clear: got %b want 0", overrun);
      else n_pass++;
      wait_tick(ok, w, fvs);
      collect(0, 1200, 0, 1'b1, 1300);
      n_total++;
      if (overrun !== 1'b1) $display("FAIL ov_set_wins: got %b want 1", overrun);
      else n_pass++;
      n_total++;
      if (fv_cnt != 1 || fv_cyc != 1209)
         $display("FAIL ov2_frame: got %0d frames at +%0d want 1 at +1209", fv_cnt, fv_cyc);
      else n_pass++;
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [16*N-1:0] smp = {$urandom, $urandom};
      bit ok;
      int w, fvs;
      ch_sample = smp;
      wait_tick(ok, w, fvs);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 3) ack_ok = 1'b0;
      end
      n_total++;
      if (dly_req !== 1'b1 || dly_ch !== 2'd1)
         $display("FAIL rm_in_wait: got req=%b ch=%0d want req=1 ch=1", dly_req, dly_ch);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if ({dly_req, busy, frame_valid} !== 3'b000 || out_samples !== '0)
         $display("FAIL rm_clear: got req=%b busy=%b fv=%b out=%h want all 0",
                  dly_req, busy, frame_valid, out_samples);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ack_ok = 1'b1;
      smp = {$urandom, $urandom};
      ch_sample = smp;
      wait_tick(ok, w, fvs);
      n_total++;
      if (!ok || w + 1 != 1134 || fvs != 0)
         $display("FAIL rm_restart: got tick at %0d frames=%0d want 1134 frames=0", w + 1, fvs);
      else n_pass++;
      collect(-1, 0, 0, 1'b0, 20);
      n_total++;
      if (fv_cnt != 1 || fv_cyc != 9 || fv_data !== (smp ^ {N{16'hFFFF}}))
         $display("FAIL rm_frame: got %0d at +%0d data %h want 1 at +9 data %h",
                  fv_cnt, fv_cyc, fv_data, smp ^ {N{16'hFFFF}});
      else n_pass++;
   endtask

   task automatic test_snapshot();
      logic [8*N-1:0] th = $urandom;
      logic [8*N-1:0] di = $urandom;
      bit ok;
      int w, fvs, bad = 0;
      ch_theta = th;
      ch_distance = di;
      ch_sample = {$urandom, $urandom};
      wait_tick(ok, w, fvs);
      collect(-1, 0, 3, 1'b0, 20);
      for (int k = 0; k < N; k++)
         if (th_obs[k] !== th[8*k +: 8] || di_obs[k] !== di[8*k +: 8]) bad++;
      n_total++;
      if (bad != 0 || hs_n != N)
         $display("FAIL snap_payload: got %0d bad of %0d want 0 of %0d", bad, hs_n, N);
      else n_pass++;
      n_total++;
      if (ch_theta !== ~th) $display("FAIL snap_drive: got %h want %h", ch_theta, ~th);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         logic [16*N-1:0] smp = {$urandom, $urandom};
         logic [8*N-1:0] th = $urandom;
         int sch = int'($urandom_range(0, N - 1));
         int sn = int'($urandom_range(0, 6));
         bit ok;
         int w, fvs, bad = 0;
         ch_sample = smp;
         ch_theta = th;
         wait_tick(ok, w, fvs);
         collect(sch, sn, 0, 1'b0, 30);
         n_total++;
         if (fv_cnt != 1 || fv_cyc != 2 * N + 1 + sn)
            $display("FAIL b2b_time[%0d]: got %0d at +%0d want 1 at +%0d",
                     r, fv_cnt, fv_cyc, 2 * N + 1 + sn);
         else n_pass++;
         n_total++;
         if (fv_data !== (smp ^ {N{16'hFFFF}}))
            $display("FAIL b2b_data[%0d]: got %h want %h", r, fv_data, smp ^ {N{16'hFFFF}});
         else n_pass++;
         for (int k = 0; k < N; k++)
            if (ch_obs[k] != k || th_obs[k] !== th[8*k +: 8] || si_obs[k] !== smp[16*k +: 16])
               bad++;
         n_total++;
         if (bad != 0 || stall_bad != 0)
            $display("FAIL b2b_payload[%0d]: got %0d bad %0d unstable want 0 0", r, bad, stall_bad);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_tick_rate();
      test_zero_wait();
      test_ack_stall();
      test_overrun();
      test_reset_mid_frame();
      test_snapshot();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
